// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-2 demux lane pair: select-to-lane mapping,
// default word width and the lane index type.
package demux_pkg;

  localparam logic LANE0_SEL      = 1'b1;
  localparam logic LANE1_SEL      = 1'b0;
  localparam int   DEFAULT_DATA_W = 8;

  typedef logic [0:0] lane_idx_t;

endpackage

// File: rtl/lane_fifo.sv
// Per-lane first-word-fall-through FIFO with a registered head word and
// registered valid, so a pushed word appears at the head one cycle later.
module lane_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  output logic              full,
  input  logic              pop_ready,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("lane_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     rd_ptr_n;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_n;
  logic              do_push;
  logic              do_pop;

  assign full = (count == FULL_CNT);

  always_comb begin
    do_push  = push && !full;
    do_pop   = valid && pop_ready;
    rd_ptr_n = do_pop ? rd_ptr + PW'(1) : rd_ptr;
    // NOTE: every path assigns count_n (default arm), so no latch is inferred.
    case ({do_push, do_pop})
      2'b10:   count_n = count + CW'(1);
      2'b01:   count_n = count - CW'(1);
      default: count_n = count;
    endcase
  end

  // NOTE: storage is left unreset; only pointers, count and the head register
  // need defined values, which keeps the array a plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
      data   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr <= rd_ptr_n;
      count  <= count_n;
      valid  <= (count_n != '0);
      // The next head is either the word landing this cycle or one already stored.
      if (count_n != '0)
        data <= (do_push && wr_ptr == rd_ptr_n) ? push_data : mem[rd_ptr_n];
    end
  end

endmodule

// File: rtl/demux_lane_dispatcher.sv
// Front end of the demux lane pair: picks a lane per word (explicit or
// round-robin), buffers each lane in a lane_fifo and counts dispatched words.
module demux_lane_dispatcher
  import demux_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sel,
  input  logic              rr_mode,
  output logic [1:0]        out_valid,
  input  logic [1:0]        out_ready,
  output logic [DATA_W-1:0] out_data0,
  output logic [DATA_W-1:0] out_data1,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1
);

  logic      rr_sel;
  logic      eff_sel;
  lane_idx_t target;
  logic      accept;
  logic [1:0] full;
  logic [1:0] push;

  // A full target stalls the stream; round-robin never skips to the other lane.
  always_comb begin
    eff_sel  = rr_mode ? rr_sel : in_sel;
    target   = (eff_sel == LANE1_SEL) ? lane_idx_t'(1) : lane_idx_t'(0);
    in_ready = !rst && !full[target];
    accept   = in_valid && in_ready;
    push     = 2'b00;
    if (accept) push[target] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_sel <= 1'b0;
      cnt0   <= '0;
      cnt1   <= '0;
    end else if (accept) begin
      if (target == lane_idx_t'(0)) cnt0 <= cnt0 + CNT_W'(1);
      else                          cnt1 <= cnt1 + CNT_W'(1);
      if (rr_mode) rr_sel <= ~rr_sel;
    end
  end

  lane_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_lane0 (
    .clk       (clk),
    .rst       (rst),
    .push      (push[0]),
    .push_data (in_data),
    .full      (full[0]),
    .pop_ready (out_ready[0]),
    .valid     (out_valid[0]),
    .data      (out_data0)
  );

  lane_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_lane1 (
    .clk       (clk),
    .rst       (rst),
    .push      (push[1]),
    .push_data (in_data),
    .full      (full[1]),
    .pop_ready (out_ready[1]),
    .valid     (out_valid[1]),
    .data      (out_data1)
  );

endmodule

// File: tb/tb_demux_lane_dispatcher.sv
// Scoreboard bench for demux_lane_dispatcher: a lane-occupancy reference model
// predicts ready/valid/counters and queues expected words; a monitor checks pops.
module tb_demux_lane_dispatcher;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_sel = 1'b0;
  logic              rr_mode = 1'b0;
  logic [1:0]        out_valid;
  logic [1:0]        out_ready = 2'b00;
  logic [DATA_W-1:0] out_data0;
  logic [DATA_W-1:0] out_data1;
  logic [CNT_W-1:0]  cnt0;
  logic [CNT_W-1:0]  cnt1;

  demux_lane_dispatcher #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .rr_mode   (rr_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .cnt0      (cnt0),
    .cnt1      (cnt1)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: lane occupancy, round-robin pointer and counters.
  logic [DATA_W-1:0] exp_q0[$];
  logic [DATA_W-1:0] exp_q1[$];
  int                occ [2] = '{0, 0};
  logic              m_rr = 1'b0;
  int                m_cnt [2] = '{0, 0};

  always @(negedge clk) begin
    logic eff;
    int   lane;
    logic exp_ready;
    logic pop0, pop1;
    check("out_valid", {30'd0, out_valid}, {30'd0, occ[1] > 0, occ[0] > 0});
    check("cnt0", {24'd0, cnt0}, m_cnt[0] % (1 << CNT_W));
    check("cnt1", {24'd0, cnt1}, m_cnt[1] % (1 << CNT_W));
    eff       = rr_mode ? m_rr : in_sel;
    lane      = eff ? 0 : 1;
    exp_ready = !rst && occ[lane] < DEPTH;
    check("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
    if (rst) begin
      occ   = '{0, 0};
      m_cnt = '{0, 0};
      m_rr  = 1'b0;
      exp_q0.delete();
      exp_q1.delete();
    end else begin
      pop0 = occ[0] > 0 && out_ready[0];
      pop1 = occ[1] > 0 && out_ready[1];
      if (in_valid && exp_ready) begin
        if (lane == 0) exp_q0.push_back(in_data);
        else           exp_q1.push_back(in_data);
        occ[lane]++;
        m_cnt[lane]++;
        if (rr_mode) m_rr = ~m_rr;
      end
      if (pop0) occ[0]--;
      if (pop1) occ[1]--;
    end
  end

  // Monitor: whenever the DUT will pop a lane, its head must match the queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid[0] && out_ready[0]) begin
        if (exp_q0.size() == 0) begin
          total++; bad++;
          $display("FAIL lane0_pop: got 0x%0h expected no word at %0t", out_data0, $time);
        end else check("lane0_data", {24'd0, out_data0}, {24'd0, exp_q0.pop_front()});
      end
      if (out_valid[1] && out_ready[1]) begin
        if (exp_q1.size() == 0) begin
          total++; bad++;
          $display("FAIL lane1_pop: got 0x%0h expected no word at %0t", out_data1, $time);
        end else check("lane1_data", {24'd0, out_data1}, {24'd0, exp_q1.pop_front()});
      end
    end
  end

  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic s,
                       input logic m, input logic [1:0] r);
    in_valid  = v;
    in_data   = d;
    in_sel    = s;
    rr_mode   = m;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    for (int i = 0; i < cycles; i++) drive(1'b1, 8'hEE, 1'b0, 1'b0, 2'b11);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    @(posedge clk);
    #1;
    // Reset then idle
    do_reset(2);
    check("data0_after_reset", {24'd0, out_data0}, 32'h0);
    check("data1_after_reset", {24'd0, out_data1}, 32'h0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 2'b11);

    // Explicit routing: sel=0 -> lane 1, sel=1 -> lane 0
    drive(1'b1, 8'hA5, 1'b0, 1'b0, 2'b11);
    check("explicit_lane1_data", {24'd0, out_data1}, 32'hA5);
    drive(1'b1, 8'h3C, 1'b1, 1'b0, 2'b11);
    check("explicit_lane0_data", {24'd0, out_data0}, 32'h3C);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 2'b11);

    // Round-robin four words
    do_reset(1);
    for (int i = 1; i <= 4; i++) drive(1'b1, DATA_W'(i), 1'b0, 1'b1, 2'b11);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 2'b11);
    check("rr_cnt0", {24'd0, cnt0}, 32'd2);
    check("rr_cnt1", {24'd0, cnt1}, 32'd2);

    // Backpressure on lane 1, lane 0 still accepted, then lane 1 drains
    do_reset(1);
    for (int i = 0; i < DEPTH; i++) drive(1'b1, DATA_W'(8'h40 + i), 1'b0, 1'b0, 2'b00);
    drive(1'b1, 8'h4F, 1'b0, 1'b0, 2'b00);
    drive(1'b1, 8'h77, 1'b1, 1'b0, 2'b00);
    for (int i = 0; i < 6; i++) drive(1'b1, DATA_W'(8'h80 + i), 1'b0, 1'b0, 2'b10);
    for (int i = 0; i < 8; i++) drive(1'b0, 8'h00, 1'b0, 1'b0, 2'b11);

    // Round-robin stall: lane 0 full while rr_sel points at it
    do_reset(1);
    drive(1'b1, 8'h11, 1'b0, 1'b1, 2'b00);
    for (int i = 0; i < DEPTH; i++) drive(1'b1, DATA_W'(8'h20 + i), 1'b1, 1'b0, 2'b00);
    for (int i = 0; i < 3; i++) drive(1'b1, 8'h55, 1'b0, 1'b1, 2'b00);
    drive(1'b1, 8'h55, 1'b0, 1'b1, 2'b01);
    drive(1'b1, 8'h56, 1'b0, 1'b1, 2'b00);
    drive(1'b1, 8'h57, 1'b0, 1'b1, 2'b00);
    for (int i = 0; i < 8; i++) drive(1'b0, 8'h00, 1'b0, 1'b1, 2'b11);

    // Reset mid-stream with three words buffered in lane 1
    for (int i = 0; i < 3; i++) drive(1'b1, DATA_W'(8'h90 + i), 1'b0, 1'b0, 2'b00);
    do_reset(1);
    check("midreset_valid", {30'd0, out_valid}, 32'd0);
    drive(1'b1, 8'hC1, 1'b1, 1'b1, 2'b00);
    check("midreset_rr_lane1", {24'd0, out_data1}, 32'hC1);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 2'b11);

    // Counter wrap on lane 0
    do_reset(1);
    for (int i = 0; i < 256; i++) drive(1'b1, DATA_W'(i), 1'b1, 1'b0, 2'b11);
    check("cnt0_wrap", {24'd0, cnt0}, 32'd0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 2'b11);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      drive(1'($urandom_range(0, 3) != 0), DATA_W'($urandom), 1'($urandom),
            1'($urandom), 2'($urandom));
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) drive(1'b0, 8'h00, 1'b0, 1'b0, 2'b11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
